neuron_layer_scheduler: RTL

//  Sequences one fully-connected layer over a single shared neuron MAC datapath.
//  For each neuron n, in turn, it clears the accumulator and streams input/weight addresses i=0..N_INPUTS-1.
//  It then drains the MAC pipeline, loads the activation register and writes result n to the output buffer.

---
 rtl/nn_sched_pkg.sv | 27 ++
 rtl/nn_index_counter.sv | 31 +++
 rtl/neuron_layer_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nn_sched_pkg.sv
// Shared definitions for the neuron layer scheduler: state encoding and
// elaboration-time sizing helpers.
package nn_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_ACCUM = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_ACT   = 3'd4;
  localparam state_t ST_WRITE = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Cycles spent on one neuron: CLEAR + ACCUM + DRAIN + ACT + WRITE.
  function automatic int neuron_cycles(input int n_inputs, input int mac_lat);
    return n_inputs + mac_lat + 4;
  endfunction

endpackage

// File: rtl/nn_index_counter.sv
// Modulo-MAX index counter with explicit wrap and a terminal-count flag.
module nn_index_counter #(
  parameter int MAX = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         last
);

  logic [W-1:0] q_q, q_d;

  assign last = (q_q == W'(MAX - 1));
  assign q    = q_q;

  // Wrap is taken at MAX-1, not at 2^W.
  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (inc) q_d = last ? '0 : q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Sequences one fully-connected layer over a shared MAC: per neuron it clears,
// streams input/weight addresses, drains the MAC pipe, activates and writes.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | clear accumulator, reset input index
// ACCUM | issue input/weight addresses, one per cycle
// DRAIN | wait MAC_LAT+1 cycles for the MAC pipe to settle
// ACT   | load activation register
// WRITE | write result for current neuron
// DONE  | one-cycle completion pulse
module neuron_layer_scheduler
  import nn_sched_pkg::*;
#(
  parameter int N_INPUTS  = 8,
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 3,
  parameter int NEU_W     = 2,
  parameter int MAC_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [IDX_W-1:0]       in_addr,
  output logic [NEU_W+IDX_W-1:0] w_addr,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   act_en,
  output logic                   out_we,
  output logic [NEU_W-1:0]       out_addr,
  output logic                   busy,
  output logic                   done
);

  localparam int DRN_W = (clog2(MAC_LAT + 1) < 1) ? 1 : clog2(MAC_LAT + 1);

  state_t           state_q, state_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             mac_en_q;

  logic [IDX_W-1:0] idx_i;
  logic [NEU_W-1:0] idx_n;
  logic             i_last, n_last;

  nn_index_counter #(.MAX(N_INPUTS), .W(IDX_W)) u_in_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_CLEAR),
    .inc  (state_q == ST_ACCUM),
    .q    (idx_i),
    .last (i_last)
  );

  nn_index_counter #(.MAX(N_NEURONS), .W(NEU_W)) u_neu_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .inc  (state_q == ST_WRITE),
    .q    (idx_n),
    .last (n_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      drn_q    <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drn_q    <= drn_d;
      mac_en_q <= (state_q == ST_ACCUM);
    end
  end

  always_comb begin
    state_d = state_q;
    drn_d   = drn_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (i_last) begin
          state_d = ST_DRAIN;
          drn_d   = DRN_W'(MAC_LAT);
        end
      end
      // Counts MAC_LAT..0, so DRAIN lasts MAC_LAT+1 cycles.
      ST_DRAIN: begin
        if (drn_q == '0) state_d = ST_ACT;
        else             drn_d   = drn_q - 1'b1;
      end
      ST_ACT:   state_d = ST_WRITE;
      ST_WRITE: state_d = n_last ? ST_DONE : ST_CLEAR;
      ST_DONE:  state_d = start ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_addr  = '0;
    w_addr   = '0;
    mac_clr  = 1'b0;
    act_en   = 1'b0;
    out_we   = 1'b0;
    out_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mac_clr = 1'b1;
        busy    = 1'b1;
      end
      ST_ACCUM: begin
        in_addr = idx_i;
        w_addr  = {idx_n, idx_i};
        busy    = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_ACT: begin
        act_en = 1'b1;
        busy   = 1'b1;
      end
      ST_WRITE: begin
        out_we   = 1'b1;
        out_addr = idx_n;
        busy     = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign mac_en = mac_en_q;

endmodule
